// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 mouse tracker.
//   - Status-byte bit indices of a 3-byte PS/2 mouse packet.
//   - Field slice positions within the 24-bit packet word.
//   - ps2_mouse_pkt_t: packed view {status, dx, dy} of that word.
//   - max2: small helper used to size the signed accumulators.
package ps2_pkg;

    // Status byte bit indices
    localparam int BTN_L    = 0;
    localparam int BTN_R    = 1;
    localparam int BTN_M    = 2;
    localparam int SYNC_BIT = 3;
    localparam int XSIGN    = 4;
    localparam int YSIGN    = 5;
    localparam int XOVF     = 6;
    localparam int YOVF     = 7;

    // Packet field slices within the 24-bit word
    localparam int PKT_W          = 24;
    localparam int PKT_BYTE_W     = 8;
    localparam int PKT_STATUS_LSB = 16;
    localparam int PKT_DX_LSB     = 8;
    localparam int PKT_DY_LSB     = 0;

    typedef struct packed {
        logic [PKT_BYTE_W-1:0] status;
        logic [PKT_BYTE_W-1:0] dx;
        logic [PKT_BYTE_W-1:0] dy;
    } ps2_mouse_pkt_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// ps2_axis_accum: one axis of the mouse position datapath.
//   S1: sign-extends the 9-bit delta (forced to zero on overflow), adds or
//       subtracts it from the base position and registers the signed sum.
//   S2: combinationally clamps the registered sum to [0, MAX].
// Ports:
//   clk_sys, rst_n : clock, asynchronous active-low reset
//   pos            : committed position of this axis
//   fwd            : S2 is committing this cycle; use clamped as the base
//   load           : S1 has a valid packet; capture the new sum
//   delta, sign    : 8-bit magnitude byte and sign bit of the movement
//   ovf            : overflow flag; the delta is ignored when set
//   clamped        : clamped S2 result, committed by the top when valid
module ps2_axis_accum
    import ps2_pkg::*;
#(
    parameter int W      = 8,
    parameter int MAX    = 159,
    parameter int INVERT = 0
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [W-1:0] pos,
    input  logic         fwd,
    input  logic         load,
    input  logic [7:0]   delta,
    input  logic         sign,
    input  logic         ovf,
    output logic [W-1:0] clamped
);

    localparam int SW = max2(W, 9) + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] base;
    logic signed [SW-1:0] d9;
    logic        [W-1:0]  base_pos;

    // Back-to-back packets: the previous packet commits in the same cycle
    // this one is summed, so take its clamped result instead of pos.
    always_comb begin
        base_pos = fwd ? clamped : pos;
        base     = {{(SW-W){1'b0}}, base_pos};
        d9       = ovf ? '0 : {{(SW-9){sign}}, sign, delta};
        if (INVERT != 0) begin
            sum_d = base - d9;
        end else begin
            sum_d = base + d9;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (load) begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        if (sum_q[SW-1]) begin
            clamped = '0;
        end else if (sum_q > MAX_S) begin
            clamped = W'(MAX);
        end else begin
            clamped = sum_q[W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: turns decoded 3-byte PS/2 mouse packets into an
// absolute, clamped cursor position plus button state.
//   S0: capture packet; reject (and count) packets whose sync bit is 0.
//   S1: per-axis delta sum (ps2_axis_accum), forwarding from S2.
//   S2: clamp, commit position/buttons, pulse pos_upd, set irq.
// Ports:
//   clk_sys, rst_n     : clock, asynchronous active-low reset
//   ps2pkt_vlk         : one-cycle packet-valid strobe
//   ps2pkt_data        : [23:16] status, [15:8] dx, [7:0] dy
//   mouse_x, mouse_y   : committed cursor position
//   mouse_btn          : {middle, right, left}
//   pos_upd            : one-cycle pulse on commit
//   irq, irq_ack       : sticky update flag and its clear
//   sync_err_cnt       : saturating count of rejected packets
module ps2_mouse_tracker
    import ps2_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 60,
    parameter int Y_INVERT = 1
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           ps2pkt_vlk,
    input  logic [23:0]    ps2pkt_data,
    output logic [X_W-1:0] mouse_x,
    output logic [Y_W-1:0] mouse_y,
    output logic [2:0]     mouse_btn,
    output logic           pos_upd,
    output logic           irq,
    input  logic           irq_ack,
    output logic [7:0]     sync_err_cnt
);

    ps2_mouse_pkt_t pkt_in;
    logic           pkt_sync;

    // S0 registers (sync bit is not kept: only valid packets set v0)
    logic           v0;
    logic [2:0]     btn0;
    logic [7:0]     dx0;
    logic [7:0]     dy0;
    logic           xsign0;
    logic           ysign0;
    logic           xovf0;
    logic           yovf0;

    // S1 registers
    logic           v1;
    logic [2:0]     btn1;

    logic [X_W-1:0] x_clamped;
    logic [Y_W-1:0] y_clamped;

    assign pkt_in   = ps2_mouse_pkt_t'(ps2pkt_data);
    assign pkt_sync = pkt_in.status[SYNC_BIT];

    ps2_axis_accum #(
        .W      (X_W),
        .MAX    (X_MAX),
        .INVERT (0)
    ) u_accum_x (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pos     (mouse_x),
        .fwd     (v1),
        .load    (v0),
        .delta   (dx0),
        .sign    (xsign0),
        .ovf     (xovf0),
        .clamped (x_clamped)
    );

    ps2_axis_accum #(
        .W      (Y_W),
        .MAX    (Y_MAX),
        .INVERT (Y_INVERT)
    ) u_accum_y (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pos     (mouse_y),
        .fwd     (v1),
        .load    (v0),
        .delta   (dy0),
        .sign    (ysign0),
        .ovf     (yovf0),
        .clamped (y_clamped)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            v0           <= 1'b0;
            btn0         <= '0;
            dx0          <= '0;
            dy0          <= '0;
            xsign0       <= 1'b0;
            ysign0       <= 1'b0;
            xovf0        <= 1'b0;
            yovf0        <= 1'b0;
            v1           <= 1'b0;
            btn1         <= '0;
            mouse_x      <= X_W'(X_INIT);
            mouse_y      <= Y_W'(Y_INIT);
            mouse_btn    <= '0;
            pos_upd      <= 1'b0;
            irq          <= 1'b0;
            sync_err_cnt <= '0;
        end else begin
            // S0: capture / reject
            v0 <= ps2pkt_vlk & pkt_sync;
            if (ps2pkt_vlk) begin
                btn0   <= {pkt_in.status[BTN_M], pkt_in.status[BTN_R], pkt_in.status[BTN_L]};
                dx0    <= pkt_in.dx;
                dy0    <= pkt_in.dy;
                xsign0 <= pkt_in.status[XSIGN];
                ysign0 <= pkt_in.status[YSIGN];
                xovf0  <= pkt_in.status[XOVF];
                yovf0  <= pkt_in.status[YOVF];
                if (!pkt_sync && sync_err_cnt != '1) begin
                    sync_err_cnt <= sync_err_cnt + 8'd1;
                end
            end

            // S1: sums are registered inside the axis accumulators
            v1 <= v0;
            if (v0) begin
                btn1 <= btn0;
            end

            // S2: commit
            pos_upd <= v1;
            if (v1) begin
                mouse_x   <= x_clamped;
                mouse_y   <= y_clamped;
                mouse_btn <= btn1;
            end

            // irq rises together with pos_upd; an ack landing in the
            // pos_upd cycle is overridden by that pulse, so set wins.
            if (v1 || pos_upd) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
Consumes decoded 3-byte PS/2 mouse packets from the PS/2 interface top and maintains an absolute, clamped cursor position and button state for the display and processor.
- Validates each packet, sign-extends the movement deltas, accumulates them into X/Y position registers and saturates at the screen limits.
- Raises a sticky interrupt/update flag for the microprocessor bus side.

Parameters:
X_W, 8, width of X position output
Y_W, 7, width of Y position output
X_MAX, 159, largest legal X (inclusive); X_MAX < 2**X_W
Y_MAX, 119, largest legal Y (inclusive); Y_MAX < 2**Y_W
X_INIT, 80, X position after reset
Y_INIT, 60, Y position after reset
Y_INVERT, 1, 1 = screen Y grows downward (position minus dy)

Ports:
clk_sys  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
ps2pkt_vlk  input  1  one-cycle strobe, packet valid
ps2pkt_data  input  24  [23:16] status byte, [15:8] dx, [7:0] dy
mouse_x  output  X_W  current X position
mouse_y  output  Y_W  current Y position
mouse_btn  output  3  {middle, right, left}
pos_upd  output  1  one-cycle pulse when position/buttons commit
irq  output  1  sticky update flag
irq_ack  input  1  clears irq
sync_err_cnt  output  8  count of rejected packets, saturating

Behaviour:
- One clock, clk_sys. Reset is asynchronous and active-low (rst_n). All state is cleared by rst_n regardless of clock.
- Reset values:
  - mouse_x = X_INIT, mouse_y = Y_INIT.
  - mouse_btn = 0, pos_upd = 0, irq = 0, sync_err_cnt = 0.
  - All pipeline valids = 0.
- Status byte bits: [0] L, [1] R, [2] M, [3] always-1, [4] X sign, [5] Y sign, [6] X ovf, [7] Y ovf.
- Stage S0 (capture), on a cycle with ps2pkt_vlk = 1:
  - Register the packet and set v0.
  - If bit3 = 0, the packet is rejected: v0 stays 0 and sync_err_cnt increments, saturating at 255.
- Stage S1 (delta):
  - dx9 = {Xsign, dx}, dy9 = {Ysign, dy}; both are 9-bit two's complement, range -256..255.
  - If X ovf = 1, dx9 = 0; likewise Y ovf forces dy9 = 0. Buttons still update.
  - Compute the signed sums in a width of max(X_W,9)+2 (X) and max(Y_W,9)+2 (Y):
    - sx = mouse_x + dx9.
    - sy = mouse_y - dy9 when Y_INVERT = 1, else mouse_y + dy9.
  - S1 sums use the committed position. Forwarding rule: if S2 is committing in the same cycle, S1 uses the S2 result, so back-to-back packets accumulate correctly.
- Stage S2 (clamp/commit):
  - Clamp each sum: <0 gives 0, >MAX gives MAX, otherwise the sum.
  - Write mouse_x, mouse_y and mouse_btn; pulse pos_upd for one cycle.
- Latency: a valid packet strobed in cycle N is reflected on the outputs, with pos_upd = 1, in cycle N+3.
- Throughput: one packet per cycle; no backpressure. Rejected packets produce no pos_upd.
- irq:
  - Set on pos_upd; cleared on irq_ack.
  - If pos_upd and irq_ack occur in the same cycle, irq stays 1 (set wins).
- Reset asserted mid-pipeline: in-flight packets are discarded and all outputs return to their reset values.
- Zero-motion packet (dx = dy = 0) still commits and pulses pos_upd; used for button-only events.

Decomposition:
- Shared package ps2_pkg:
  - Status-bit index constants: BTN_L, BTN_R, BTN_M, SYNC_BIT, XSIGN, YSIGN, XOVF, YOVF.
  - Packet field slice localparams.
  - Typedef ps2_mouse_pkt_t, a packed struct {status, dx, dy}.
- One sub-module, ps2_axis_accum, instantiated once per axis:
  - Inputs: width, MAX, invert flag.
  - Function: sign-extend, add/subtract, clamp.
  - The S0/S2 control and irq logic stay in the top module.

Test Plan:
1. Reset, then a packet with status=0x09, dx=0x0A, dy=0x05 -> at N+3: mouse_x=90, mouse_y=55, mouse_btn=3'b001, pos_upd=1, irq=1.
2. Starting at 80,60, status=0x18, dx=0x9C (dx9=-100) -> mouse_x clamps to 0. Then status=0x08, dx=0xFF, repeated -> mouse_x=159 and stays 159.
3. status=0x48 (X ovf), dx=0x50, dy=0x02 -> mouse_x unchanged, mouse_y decreases by 2, pos_upd=1.
4. status=0x01 (bit3=0) -> no pos_upd, position unchanged, sync_err_cnt=1. 300 such packets -> sync_err_cnt=255.
5. Two valid packets on consecutive cycles, each dx=+5 from X=80 -> commits at N+3 (85) and N+4 (90); no lost increment.
6. irq_ack asserted in the same cycle as pos_upd -> irq stays 1. irq_ack alone next cycle -> irq=0. rst_n asserted with a packet in S1 -> outputs reset, no pos_upd after release.
